// File: rtl/ex_muldiv_unit_pkg.sv
// Shared M-extension constants, FSM state type and operand-signedness helpers
// for the EX-stage multiply/divide unit.
package ex_muldiv_unit_pkg;

  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } md_state_e;

  // Latched per-op control: op class, which half to return, and sign fixes.
  typedef struct packed {
    logic is_div;
    logic sel_hi;
    logic neg_q;
    logic neg_r;
  } md_op_t;

  function automatic logic rs1_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic rs2_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// ID/EX-side operand bundle and EX/MEM-side result bundle of the mul/div unit.
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            valid_i;
  logic [9:0]      func_i;
  logic [XLEN-1:0] rs1_data_i;
  logic [XLEN-1:0] rs2_data_i;
  logic [4:0]      rd_addr_i;
  logic            flush_i;
  logic            stall_o;
  logic            busy_o;
  logic            done_o;
  logic            RegWrite_o;
  logic [4:0]      rd_addr_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output valid_i, func_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
    input  stall_o, busy_o, done_o, RegWrite_o, rd_addr_o, result_o
  );

  modport slave (
    input  valid_i, func_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
    output stall_o, busy_o, done_o, RegWrite_o, rd_addr_o, result_o
  );
endinterface

// File: rtl/ex_muldiv_unit_datapath.sv
// Operand/accumulator registers for the iterative mul/div: one radix-2
// shift-add or restoring shift-subtract step per enabled cycle.
module muldiv_datapath
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            fin_i,
  input  logic [2:0]      f3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            special_o,
  output logic [XLEN-1:0] result_q
);

  md_op_t              op_q;
  logic [XLEN-1:0]     opb_q;
  logic [2*XLEN-1:0]   acc_q;

  logic                a_neg, b_neg, is_div_in, div_zero, div_ovf;
  logic [XLEN-1:0]     a_mag, b_mag, special_val;
  logic [XLEN:0]       mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0]   acc_step, prod_fix;
  logic [XLEN-1:0]     quo, rem, fin_val;

  always_comb begin
    a_neg     = rs1_is_signed(f3_i) & rs1_i[XLEN-1];
    b_neg     = rs2_is_signed(f3_i) & rs2_i[XLEN-1];
    a_mag     = a_neg ? -rs1_i : rs1_i;
    b_mag     = b_neg ? -rs2_i : rs2_i;
    is_div_in = f3_i[2];
    div_zero  = is_div_in & (rs2_i == '0);
    div_ovf   = is_div_in & ~f3_i[0] & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) &
                (rs2_i == '1);
    special_o = div_zero | div_ovf;
    if (div_zero) special_val = f3_i[1] ? rs1_i : '1;
    else          special_val = f3_i[1] ? '0 : rs1_i;
  end

  // Mul keeps {partial_hi, multiplier} in acc; div keeps {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    div_shift = acc_q[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opb_q};
    if (op_q.is_div) begin
      if (div_diff[XLEN]) acc_step = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      else                acc_step = {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  // Sign correction sees the final step's accumulator so it lands on the same edge.
  always_comb begin
    prod_fix = op_q.neg_q ? -acc_step : acc_step;
    quo      = op_q.neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem      = op_q.neg_r ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    if (op_q.is_div) fin_val = op_q.sel_hi ? rem : quo;
    else             fin_val = op_q.sel_hi ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q     <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else if (load_i) begin
      op_q.is_div <= is_div_in;
      op_q.sel_hi <= is_div_in ? f3_i[1] : (f3_i != F3_MUL);
      op_q.neg_q  <= a_neg ^ b_neg;
      op_q.neg_r  <= a_neg;
      opb_q       <= is_div_in ? b_mag : a_mag;
      acc_q       <= {{XLEN{1'b0}}, (is_div_in ? a_mag : b_mag)};
      if (special_o) result_q <= special_val;
    end else if (step_i) begin
      acc_q <= acc_step;
      if (fin_i) result_q <= fin_val;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage RV32M multiply/divide unit: FSM, pipeline stall and flush control
// around the iterative datapath.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  ex_muldiv_unit_if.slave bus
);

  md_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]      rd_q;
  logic            start, special, step, last;
  logic [XLEN-1:0] result_q;

  always_comb begin
    start = bus.valid_i & (bus.func_i[9:3] == MULDIV_FUNCT7) &
            (state_q == IDLE) & ~bus.flush_i;
    step  = (state_q == CALC) & ~bus.flush_i;
    last  = (cnt_q == CNT_W'(XLEN-1));
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = special ? DONE : CALC;
      CALC: begin
        if (bus.flush_i) state_d = IDLE;
        else if (last)   state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        cnt_q <= '0;
        rd_q  <= bus.rd_addr_i;
      end else if (step) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  muldiv_datapath #(.XLEN(XLEN)) u_datapath (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (start),
    .step_i    (step),
    .fin_i     (step & last),
    .f3_i      (bus.func_i[2:0]),
    .rs1_i     (bus.rs1_data_i),
    .rs2_i     (bus.rs2_data_i),
    .special_o (special),
    .result_q  (result_q)
  );

  // Flush kills the DONE pulse and releases the stall in the same cycle.
  always_comb begin
    bus.stall_o    = start | step;
    bus.busy_o     = (state_q != IDLE);
    bus.done_o     = (state_q == DONE) & ~bus.flush_i;
    bus.RegWrite_o = bus.done_o & (rd_q != '0);
    bus.rd_addr_o  = rd_q;
    bus.result_o   = bus.done_o ? result_q : '0;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide engine in the EX stage.
- Consumes the operand, func and rd fields held in the ID/EX pipeline register.
- Holds stall_o high to freeze PC, IF/ID and ID/EX while it computes.
- Presents a one-cycle result with register write enable to the EX/MEM path.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.
- CNT_W, 5, iteration counter width, equal to clog2(XLEN).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- valid_i  in  1  ID/EX holds an M-extension op; decoder-qualified.
- func_i  in  10  {funct7[6:0], funct3[2:0]} from ID/EX.
- rs1_data_i  in  XLEN  forwarded rs1 operand.
- rs2_data_i  in  XLEN  forwarded rs2 operand.
- rd_addr_i  in  5  destination register.
- flush_i  in  1  abort the in-flight op (branch/exception flush).
- stall_o  out  1  freeze upstream pipeline registers.
- busy_o  out  1  state is not IDLE.
- done_o  out  1  result valid this cycle.
- RegWrite_o  out  1  equal to done_o when rd_addr_o != 0.
- rd_addr_o  out  5  latched rd.
- result_o  out  XLEN  final result; 0 when done_o=0.

Behaviour:
- Reset (rst_i=1 at an edge): state=IDLE, counter=0, all datapath registers 0.
- Reset outputs: stall_o=0, busy_o=0, done_o=0, RegWrite_o=0, rd_addr_o=0, result_o=0.
- Reset overrides flush_i and valid_i; a reset mid-operation discards the op with no done pulse.
- start = valid_i & (func_i[9:3]==7'b0000001) & state==IDLE & !flush_i. Non-M func with valid_i is ignored.
- funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- stall_o is combinational: start | state==CALC.
- stall_o is 0 in DONE, so ID/EX advances on the DONE cycle.
- States: IDLE, CALC, DONE.
- IDLE -> CALC on start. At this edge latch:
  - operand magnitudes; signed ops take abs of the signed operands;
  - result-sign flag;
  - op class (mul or div) and hi/lo or quotient/remainder select;
  - rd_addr_i.
- IDLE -> DONE directly on start for these special cases (total stall = 1 cycle):
  - divide by zero: DIV/DIVU quotient = all ones; REM/REMU = rs1 unchanged;
  - signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV = 0x80000000; REM = 0.
- CALC, one step per cycle, counter 0..XLEN-1:
  - mul: radix-2 shift-add into a 2*XLEN accumulator;
  - div: restoring shift-subtract producing quotient and remainder.
- CALC -> DONE when counter==XLEN-1. Normal stall = 1 + XLEN = 33 cycles.
- DONE: done_o=1 for exactly one cycle and result_o is valid.
- Result sign correction is registered on the CALC->DONE edge:
  - MUL/MULH: negate the 64-bit product if sign(rs1)!=sign(rs2);
  - MULHSU: rs1 signed, rs2 unsigned;
  - MUL returns low XLEN bits, MULH* return high XLEN bits;
  - DIV: quotient negated if signs differ; REM: remainder takes dividend sign.
- DONE -> IDLE unconditionally. valid_i during DONE is the same op and is ignored.
- A new op can start the cycle after DONE.
- flush_i in CALC or DONE: state -> IDLE at the next edge.
  - done_o and RegWrite_o are forced 0 in that same cycle.
  - stall_o deasserts combinationally when flush_i=1.
- flush_i together with start: no start is taken.
- rd_addr_i==0: computation runs normally, done_o=1, RegWrite_o=0.

Decomposition:
- Shared package (core-wide pkg, alongside ALUOp/func constants):
  - MULDIV_FUNCT7 = 7'b0000001;
  - funct3 localparams F3_MUL..F3_REMU;
  - state encoding IDLE=2'b00, CALC=2'b01, DONE=2'b10.
- The top block owns the FSM, stall logic and flush handling.
- Sub-module muldiv_datapath: operand/accumulator registers and one shift-add or shift-subtract step per enable. It is controlled by the top FSM and has no handshakes of its own.

Test Plan:
- MUL 7 * 0xFFFFFFFD (-3), rd=5 -> stall_o high 33 cycles; done_o pulse with result_o=0xFFFFFFEB, RegWrite_o=1, rd_addr_o=5.
- MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF * 2 -> 0xFFFFFFFF.
- DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
- Special cases: DIVU 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. Each shows a 1-cycle stall, then done.
- Flush and reset:
  - flush_i on the 10th CALC cycle -> no done_o; stall_o low that cycle; IDLE next; a back-to-back new MUL completes correctly.
  - rst_i mid-CALC -> all outputs 0 next cycle.
- Back-to-back DIV then MUL with rd=0 -> two done pulses 34 cycles apart; second has RegWrite_o=0; valid_i held through DONE does not restart.
